// File: rtl/alu_unit_if.sv
// alu_unit_if: issue bus from the reservation station and ALU CDB/redirect bus to RS, LSB and ROB.
interface alu_unit_if #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int OPT_W = 7
);
    logic             valid_in;
    logic [OPT_W-1:0] inst_type_in;
    logic [ROB_W-1:0] alias_in;
    logic [XLEN-1:0]  vi_in;
    logic [XLEN-1:0]  vj_in;
    logic [XLEN-1:0]  imm_in;
    logic [XLEN-1:0]  pc_in;
    logic             busy;
    logic             valid_out;
    logic [ROB_W-1:0] alias_out;
    logic [XLEN-1:0]  result_out;
    logic             jump_out;
    logic [XLEN-1:0]  target_out;

    modport master (
        output valid_in, inst_type_in, alias_in, vi_in, vj_in, imm_in, pc_in,
        input  busy, valid_out, alias_out, result_out, jump_out, target_out
    );
    modport slave (
        input  valid_in, inst_type_in, alias_in, vi_in, vj_in, imm_in, pc_in,
        output busy, valid_out, alias_out, result_out, jump_out, target_out
    );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: RV32I execute stage broadcasting {valid, alias, result} plus jump/target on the ALU CDB.
// Defining ALU_MULDIV_EN adds RV32M: single-cycle multiply and a 32-step restoring divide FSM.
module alu_unit #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 4,
    parameter int OPT_W = 7
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      rollback,
    alu_unit_if.slave bus
);
    localparam logic [OPT_W-1:0] LUI = OPT_W'(1), AUIPC = OPT_W'(2), JAL = OPT_W'(3), JALR = OPT_W'(4);
    localparam logic [OPT_W-1:0] BEQ = OPT_W'(5), BNE = OPT_W'(6), BLT = OPT_W'(7), BGE = OPT_W'(8);
    localparam logic [OPT_W-1:0] BLTU = OPT_W'(9), BGEU = OPT_W'(10);
    localparam logic [OPT_W-1:0] ADD = OPT_W'(11), SUB = OPT_W'(12), SLL = OPT_W'(13), SLT = OPT_W'(14);
    localparam logic [OPT_W-1:0] SLTU = OPT_W'(15), XOR = OPT_W'(16), SRL = OPT_W'(17), SRA = OPT_W'(18);
    localparam logic [OPT_W-1:0] OR = OPT_W'(19), AND = OPT_W'(20);
    localparam logic [OPT_W-1:0] ADDI = OPT_W'(21), SLTI = OPT_W'(22), SLTIU = OPT_W'(23), XORI = OPT_W'(24);
    localparam logic [OPT_W-1:0] ORI = OPT_W'(25), ANDI = OPT_W'(26), SLLI = OPT_W'(27), SRLI = OPT_W'(28);
    localparam logic [OPT_W-1:0] SRAI = OPT_W'(29);

    logic [OPT_W-1:0] op;
    logic [XLEN-1:0]  vi, vj, imm, pc, b, pc4, pc_imm, res, tgt;
    logic [XLEN-1:0]  r_r, t_r, fin_res, fin_tgt;
    logic [ROB_W-1:0] a_r, fin_alias;
    logic [4:0]       sh;
    logic             eq, lt, ltu, br, jmp, acc, start, fin, v_r, j_r;

    assign op     = bus.inst_type_in;
    assign vi     = bus.vi_in;
    assign vj     = bus.vj_in;
    assign imm    = bus.imm_in;
    assign pc     = bus.pc_in;
    assign b      = (op inside {ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI}) ? imm : vj;
    assign sh     = b[4:0];
    assign pc4    = pc + XLEN'(4);
    assign pc_imm = pc + imm;
    assign eq     = vi == b;
    assign lt     = $signed(vi) < $signed(b);
    assign ltu    = vi < b;
    assign br     = op == BEQ ? eq : op == BNE ? ~eq : op == BLT ? lt : op == BGE ? ~lt :
                    op == BLTU ? ltu : op == BGEU ? ~ltu : 1'b0;
    assign acc    = bus.valid_in & ~bus.busy;

`ifdef ALU_MULDIV_EN
    localparam logic [OPT_W-1:0] MUL = OPT_W'(30), MULH = OPT_W'(31), MULHSU = OPT_W'(32), MULHU = OPT_W'(33);
    localparam logic [OPT_W-1:0] DIV = OPT_W'(34), DIVU = OPT_W'(35), REM = OPT_W'(36), REMU = OPT_W'(37);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
    state_t state, state_nx;

    logic signed [2*XLEN+1:0] prod;
    logic [XLEN-1:0] abs_a, abs_b, quo, rem, dvs, q_out, r_out, d_tgt;
    logic [XLEN:0]   shl, dif;
    logic [ROB_W-1:0] d_alias;
    logic [4:0]      cnt;
    logic            sgn, neg_a, neg_b, dz, ovf, neg_q, neg_r, is_rem;

    // One 33x33 signed multiplier; the extra top bit selects signed/unsigned per operand.
    assign prod  = $signed({op != MULHU & vi[XLEN-1], vi}) * $signed({(op == MUL | op == MULH) & vj[XLEN-1], vj});
    assign sgn   = op == DIV | op == REM;
    assign neg_a = sgn & vi[XLEN-1];
    assign neg_b = sgn & vj[XLEN-1];
    assign abs_a = neg_a ? -vi : vi;
    assign abs_b = neg_b ? -vj : vj;
    assign dz    = vj == '0;
    assign ovf   = sgn & vi == {1'b1, {(XLEN-1){1'b0}}} & (&vj);
    assign start = acc & (op inside {DIV, DIVU, REM, REMU}) & ~dz & ~ovf;
    assign shl   = {rem, quo[XLEN-1]};
    assign dif   = shl - {1'b0, dvs};
    assign q_out = neg_q ? -quo : quo;
    assign r_out = neg_r ? -rem : rem;
    assign fin       = state == DONE;
    assign fin_res   = is_rem ? r_out : q_out;
    assign fin_tgt   = d_tgt;
    assign fin_alias = d_alias;
    assign bus.busy  = state != IDLE;

    always_ff @(posedge clk)
        if (rst | rollback) state <= IDLE;
        else if (rdy) state <= state_nx;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (start ? DIVIDE : IDLE) :
                   state == DIVIDE ? (cnt == 5'd31 ? DONE : DIVIDE) : IDLE;
    end

    // Restoring divide on magnitudes; the dividend shifts out of quo as quotient bits shift in.
    always_ff @(posedge clk)
        if (rdy) begin
            if (start) begin
                quo     <= abs_a;
                rem     <= '0;
                dvs     <= abs_b;
                cnt     <= '0;
                neg_q   <= neg_a ^ neg_b;
                neg_r   <= neg_a;
                is_rem  <= op == REM | op == REMU;
                d_alias <= bus.alias_in;
                d_tgt   <= pc4;
            end else if (state == DIVIDE) begin
                rem <= dif[XLEN] ? shl[XLEN-1:0] : dif[XLEN-1:0];
                quo <= {quo[XLEN-2:0], ~dif[XLEN]};
                cnt <= cnt + 5'd1;
            end
        end
`else
    assign start     = 1'b0;
    assign fin       = 1'b0;
    assign fin_res   = '0;
    assign fin_tgt   = '0;
    assign fin_alias = '0;
    assign bus.busy  = 1'b0;
`endif

    always_comb begin
        res = '0;
        jmp = 1'b0;
        tgt = pc4;
        case (op)
            LUI:               res = imm;
            AUIPC:             res = pc_imm;
            JAL:               begin res = pc4; jmp = 1'b1; tgt = pc_imm; end
            JALR:              begin res = pc4; jmp = 1'b1; tgt = (vi + imm) & ~XLEN'(1); end
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin jmp = br; tgt = br ? pc_imm : pc4; end
            ADD, ADDI:         res = vi + b;
            SUB:               res = vi - vj;
            SLL, SLLI:         res = vi << sh;
            SLT, SLTI:         res = XLEN'(lt);
            SLTU, SLTIU:       res = XLEN'(ltu);
            XOR, XORI:         res = vi ^ b;
            SRL, SRLI:         res = vi >> sh;
            SRA, SRAI:         res = XLEN'($signed(vi) >>> sh);
            OR, ORI:           res = vi | b;
            AND, ANDI:         res = vi & b;
`ifdef ALU_MULDIV_EN
            MUL:               res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: res = prod[2*XLEN-1:XLEN];
            DIV, DIVU, REM, REMU:
                res = dz ? ((op == REM | op == REMU) ? vi : '1) : ovf ? (op == DIV ? vi : '0) : '0;
`endif
            default:           res = '0;
        endcase
    end

    always_ff @(posedge clk)
        if (rst | rollback) begin
            v_r <= 1'b0;
            a_r <= '0;
            r_r <= '0;
            j_r <= 1'b0;
            t_r <= '0;
        end else if (rdy) begin
            if (acc & ~start) begin
                v_r <= 1'b1;
                a_r <= bus.alias_in;
                r_r <= res;
                j_r <= jmp;
                t_r <= tgt;
            end else if (fin) begin
                v_r <= 1'b1;
                a_r <= fin_alias;
                r_r <= fin_res;
                j_r <= 1'b0;
                t_r <= fin_tgt;
            end else begin
                v_r <= 1'b0;
                a_r <= '0;
            end
        end

    assign bus.valid_out  = v_r;
    assign bus.alias_out  = a_r;
    assign bus.result_out = r_r;
    assign bus.jump_out   = j_r;
    assign bus.target_out = t_r;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with hand-computed CDB values;
// RV32M vectors run when ALU_MULDIV_EN is defined.
module tb_alu_unit;
    localparam logic [6:0] LUI = 7'd1, AUIPC = 7'd2, JAL = 7'd3, JALR = 7'd4, BEQ = 7'd5, BNE = 7'd6;
    localparam logic [6:0] BLT = 7'd7, BGE = 7'd8, BLTU = 7'd9, ADD = 7'd11, SUB = 7'd12, SLL = 7'd13;
    localparam logic [6:0] SRA = 7'd18, SLTI = 7'd22, SLTIU = 7'd23, SRLI = 7'd28;
    localparam logic [6:0] MUL = 7'd30, MULH = 7'd31, MULHSU = 7'd32, MULHU = 7'd33;
    localparam logic [6:0] DIV = 7'd34, DIVU = 7'd35, REM = 7'd36, REMU = 7'd37;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
    int passed = 0, failed = 0, total = 0, bad;

    alu_unit_if #(.XLEN(32), .ROB_W(4), .OPT_W(7)) bus ();
    alu_unit dut (.clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [3:0] al, input logic [31:0] vi, input logic [31:0] vj,
                         input logic [31:0] imm, input logic [31:0] pc);
        bus.valid_in = 1'b1;
        bus.inst_type_in = op;
        bus.alias_in = al;
        bus.vi_in = vi;
        bus.vj_in = vj;
        bus.imm_in = imm;
        bus.pc_in = pc;
    endtask

    task automatic issue(input logic [6:0] op, input logic [3:0] al, input logic [31:0] vi, input logic [31:0] vj,
                         input logic [31:0] imm, input logic [31:0] pc);
        drive(op, al, vi, vj, imm, pc);
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic cdb(input string tag, input logic [3:0] al, input logic [31:0] res, input logic jmp,
                       input logic [31:0] tgt);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
        chk({tag, ".alias"}, 32'(bus.alias_out), 32'(al));
        chk({tag, ".result"}, bus.result_out, res);
        chk({tag, ".jump"}, 32'(bus.jump_out), 32'(jmp));
        chk({tag, ".target"}, bus.target_out, tgt);
    endtask

    task automatic div_run(input string tag, input logic [6:0] op, input logic [3:0] al, input logic [31:0] vi,
                           input logic [31:0] vj, input logic [31:0] res);
        issue(op, al, vi, vj, 32'd0, 32'h80);
        bad = 0;
        repeat (32) begin
            tick();
            if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        chk({tag, ".wait"}, 32'(bad), 32'd0);
        tick();
        cdb(tag, al, res, 1'b0, 32'h84);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.inst_type_in = '0;
        bus.alias_in = '0;
        bus.vi_in = '0;
        bus.vj_in = '0;
        bus.imm_in = '0;
        bus.pc_in = '0;
        tick();
        tick();
        chk("rst.valid", 32'(bus.valid_out), 32'd0);
        chk("rst.alias", 32'(bus.alias_out), 32'd0);
        chk("rst.result", bus.result_out, 32'd0);
        chk("rst.jump", 32'(bus.jump_out), 32'd0);
        chk("rst.target", bus.target_out, 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        issue(ADD, 4'd3, 32'd5, 32'd7, 32'd0, 32'd0);
        cdb("add", 4'd3, 32'd12, 1'b0, 32'd4);
        tick();
        chk("add.drop_valid", 32'(bus.valid_out), 32'd0);
        chk("add.drop_alias", 32'(bus.alias_out), 32'd0);

        issue(BLT, 4'd1, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        cdb("blt", 4'd1, 32'd0, 1'b1, 32'h120);
        issue(BLTU, 4'd2, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        cdb("bltu", 4'd2, 32'd0, 1'b0, 32'h104);
        issue(JALR, 4'd2, 32'h1003, 32'd0, 32'd4, 32'h40);
        cdb("jalr", 4'd2, 32'h44, 1'b1, 32'h1006);

        drive(ADD, 4'd1, 32'd5, 32'd7, 32'd0, 32'd0);
        tick();
        cdb("b2b.add", 4'd1, 32'd12, 1'b0, 32'd4);
        drive(SUB, 4'd2, 32'd3, 32'd5, 32'd0, 32'd8);
        tick();
        cdb("b2b.sub", 4'd2, 32'hFFFF_FFFE, 1'b0, 32'd12);
        bus.valid_in = 1'b0;
        tick();
        chk("b2b.idle", 32'(bus.valid_out), 32'd0);

        issue(SRA, 4'd3, 32'h8000_0000, 32'd36, 32'd0, 32'd0);
        chk("sra", bus.result_out, 32'hF800_0000);
        issue(SRLI, 4'd3, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
        chk("srli", bus.result_out, 32'h0800_0000);
        issue(SLL, 4'd3, 32'd1, 32'd33, 32'd0, 32'd0);
        chk("sll", bus.result_out, 32'd2);
        issue(SLTI, 4'd3, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0);
        chk("slti", bus.result_out, 32'd0);
        issue(SLTIU, 4'd3, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0);
        chk("sltiu", bus.result_out, 32'd1);
        issue(LUI, 4'd4, 32'd0, 32'd0, 32'h1234_5000, 32'd0);
        chk("lui", bus.result_out, 32'h1234_5000);
        issue(AUIPC, 4'd4, 32'd0, 32'd0, 32'h2000, 32'h1000);
        chk("auipc", bus.result_out, 32'h3000);
        issue(JAL, 4'd5, 32'd0, 32'd0, 32'h10, 32'h200);
        cdb("jal", 4'd5, 32'h204, 1'b1, 32'h210);
        issue(BGE, 4'd5, 32'd5, 32'd5, 32'd8, 32'd0);
        cdb("bge", 4'd5, 32'd0, 1'b1, 32'd8);
        issue(BNE, 4'd5, 32'd5, 32'd5, 32'd8, 32'd0);
        cdb("bne", 4'd5, 32'd0, 1'b0, 32'd4);
        issue(BEQ, 4'd5, 32'd5, 32'd6, 32'd8, 32'h30);
        cdb("beq", 4'd5, 32'd0, 1'b0, 32'h34);
        issue(7'd100, 4'd6, 32'd1, 32'd1, 32'd1, 32'h10);
        cdb("unknown", 4'd6, 32'd0, 1'b0, 32'h14);

        issue(ADD, 4'd4, 32'd1, 32'd1, 32'd0, 32'd0);
        rdy = 1'b0;
        drive(SUB, 4'd5, 32'd9, 32'd1, 32'd0, 32'd0);
        tick();
        tick();
        cdb("rdy0.hold", 4'd4, 32'd2, 1'b0, 32'd4);
        bus.valid_in = 1'b0;
        rdy = 1'b1;
        tick();
        chk("rdy1.valid", 32'(bus.valid_out), 32'd0);
        chk("rdy1.alias", 32'(bus.alias_out), 32'd0);

        issue(ADD, 4'd7, 32'd2, 32'd3, 32'd0, 32'd0);
        rollback = 1'b1;
        drive(ADD, 4'd8, 32'd2, 32'd3, 32'd0, 32'd0);
        tick();
        rollback = 1'b0;
        bus.valid_in = 1'b0;
        chk("rb.valid", 32'(bus.valid_out), 32'd0);
        chk("rb.result", bus.result_out, 32'd0);
        chk("rb.target", bus.target_out, 32'd0);

        issue(ADD, 4'd7, 32'd2, 32'd3, 32'd0, 32'd0);
        rdy = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_over_rdy.valid", 32'(bus.valid_out), 32'd0);
        chk("rst_over_rdy.result", bus.result_out, 32'd0);
        rst = 1'b0;
        rdy = 1'b1;
        tick();

`ifdef ALU_MULDIV_EN
        issue(MUL, 4'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        chk("mul", bus.result_out, 32'hFFFF_FFFE);
        issue(MULH, 4'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        chk("mulh", bus.result_out, 32'hFFFF_FFFF);
        issue(MULHU, 4'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        chk("mulhu", bus.result_out, 32'd1);
        issue(MULHSU, 4'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        chk("mulhsu", bus.result_out, 32'hFFFF_FFFF);

        issue(DIVU, 4'd5, 32'd100, 32'd7, 32'd0, 32'h80);
        chk("divu.busy", 32'(bus.busy), 32'd1);
        chk("divu.novalid", 32'(bus.valid_out), 32'd0);
        drive(ADD, 4'd9, 32'd1, 32'd1, 32'd0, 32'd0);
        bad = 0;
        repeat (32) begin
            tick();
            if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        chk("divu.wait", 32'(bad), 32'd0);
        tick();
        bus.valid_in = 1'b0;
        cdb("divu", 4'd5, 32'd14, 1'b0, 32'h84);
        chk("divu.busy_clear", 32'(bus.busy), 32'd0);
        tick();
        chk("divu.ignored_issue", 32'(bus.valid_out), 32'd0);

        div_run("div_neg", DIV, 4'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        div_run("rem_neg", REM, 4'd3, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        div_run("remu", REMU, 4'd4, 32'd100, 32'd7, 32'd2);

        issue(DIV, 4'd3, 32'd123, 32'd0, 32'd0, 32'd0);
        cdb("div0", 4'd3, 32'hFFFF_FFFF, 1'b0, 32'd4);
        chk("div0.busy", 32'(bus.busy), 32'd0);
        issue(REMU, 4'd3, 32'd123, 32'd0, 32'd0, 32'd0);
        chk("remu0", bus.result_out, 32'd123);
        issue(DIV, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        chk("div_ovf", bus.result_out, 32'h8000_0000);
        issue(REM, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        chk("rem_ovf", bus.result_out, 32'd0);

        issue(DIVU, 4'd6, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (9) tick();
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        chk("div_rb.valid", 32'(bus.valid_out), 32'd0);
        chk("div_rb.busy", 32'(bus.busy), 32'd0);
        bad = 0;
        repeat (30) begin
            tick();
            if (bus.valid_out !== 1'b0) bad++;
        end
        chk("div_rb.silent", 32'(bad), 32'd0);

        issue(DIVU, 4'd7, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (5) tick();
        rdy = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.valid_out !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        rdy = 1'b1;
        repeat (27) begin
            tick();
            if (bus.valid_out !== 1'b0) bad++;
        end
        chk("div_rdy.wait", 32'(bad), 32'd0);
        tick();
        cdb("div_rdy", 4'd7, 32'd14, 1'b0, 32'd4);
`else
        issue(MUL, 4'd2, 32'd3, 32'd4, 32'd0, 32'h20);
        cdb("mul_unknown", 4'd2, 32'd0, 1'b0, 32'h24);
        issue(DIVU, 4'd3, 32'd100, 32'd7, 32'd0, 32'h20);
        cdb("divu_unknown", 4'd3, 32'd0, 1'b0, 32'h24);
        chk("divu_unknown.busy", 32'(bus.busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
